// File: rtl/xadc_drp_responder.sv
// Stand-in for the XADC wizard's DRP port and end-of-conversion sequencer.
// It converts four aux channels round-robin and answers DRP transactions after a fixed latency.
module xadc_drp_responder #(
    parameter int         DRP_LAT     = 4,
    parameter int         CONV_CYCLES = 26,
    parameter logic [3:0] SEQ_RST     = 4'hF
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic [6:0]  daddr_in,
    input  logic        den_in,
    input  logic        dwe_in,
    input  logic [15:0] di_in,
    output logic [15:0] do_out,
    output logic        drdy_out,
    output logic        busy_out,
    output logic        eoc_out,
    output logic [4:0]  channel_out,
    output logic        err_out,
    input  logic [11:0] aux2_in,
    input  logic [11:0] aux3_in,
    input  logic [11:0] aux10_in,
    input  logic [11:0] aux11_in
);
    localparam int         TW        = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [TW-1:0] CONV_INIT = TW'(CONV_CYCLES - 2);
    localparam logic [3:0] LAT_INIT  = 4'(DRP_LAT - 1);

    typedef enum logic [1:0] {DRP_IDLE, DRP_WAIT, DRP_RESP} drp_state_t;
    typedef enum logic [1:0] {SEQ_OFF, SEQ_CONV, SEQ_EOC} seq_state_t;

    drp_state_t    drp_state_reg, drp_state_next;
    seq_state_t    seq_state_reg, seq_state_next;
    logic [3:0]    lat_cnt_reg, lat_cnt_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [1:0]    sel_reg, sel_next;
    logic [4:0]    chan_reg;
    logic          wr_flag_reg;
    logic [15:0]   snap_reg;
    logic          err_reg;
    logic [15:0]   cfg40_reg, cfg41_reg, cfg42_reg;
    logic [15:0]   res_arr [4];
    logic [11:0]   aux_arr [4];
    logic [15:0]   rd_data;
    logic [3:0]    eff_mask;
    logic [1:0]    pick_idx;
    logic [1:0]    pick_base;
    logic          accept, wr_accept, conv_done;

    function automatic logic [4:0] ch_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    ch_addr = 5'h12;
            2'd1:    ch_addr = 5'h13;
            2'd2:    ch_addr = 5'h1A;
            default: ch_addr = 5'h1B;
        endcase
    endfunction

    assign aux_arr[0] = aux2_in;
    assign aux_arr[1] = aux3_in;
    assign aux_arr[2] = aux10_in;
    assign aux_arr[3] = aux11_in;

    assign accept    = (drp_state_reg == DRP_IDLE) && den_in;
    assign wr_accept = accept && dwe_in;
    assign conv_done = (seq_state_reg == SEQ_CONV) && (timer_reg == '0);
    // A write to 0x41 landing on a selection cycle must steer that selection.
    assign eff_mask  = (wr_accept && daddr_in == 7'h41) ? di_in[3:0] : cfg41_reg[3:0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_res
            logic [15:0] value_reg;
            always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
                if (!CPU_RESETN)
                    value_reg <= '0;
                else if (conv_done && sel_reg == 2'(gi))
                    value_reg <= {aux_arr[gi], 4'b0};
            end
            assign res_arr[gi] = value_reg;
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        case (daddr_in)
            7'h12:   rd_data = res_arr[0];
            7'h13:   rd_data = res_arr[1];
            7'h1A:   rd_data = res_arr[2];
            7'h1B:   rd_data = res_arr[3];
            7'h40:   rd_data = cfg40_reg;
            7'h41:   rd_data = cfg41_reg;
            7'h42:   rd_data = cfg42_reg;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            cfg40_reg   <= '0;
            cfg41_reg   <= {12'h0, SEQ_RST};
            cfg42_reg   <= '0;
            wr_flag_reg <= 1'b0;
            snap_reg    <= '0;
            err_reg     <= 1'b0;
        end else begin
            if (wr_accept) begin
                case (daddr_in)
                    7'h40:   cfg40_reg <= di_in;
                    7'h41:   cfg41_reg <= di_in;
                    7'h42:   cfg42_reg <= di_in;
                    default: ;
                endcase
            end
            if (accept) begin
                wr_flag_reg <= dwe_in;
                snap_reg    <= rd_data;
            end
            if (den_in && drp_state_reg != DRP_IDLE)
                err_reg <= 1'b1;
        end
    end

    // DRP FSM
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            drp_state_reg <= DRP_IDLE;
            lat_cnt_reg   <= '0;
        end else begin
            drp_state_reg <= drp_state_next;
            lat_cnt_reg   <= lat_cnt_next;
        end
    end

    always_comb begin
        drp_state_next = drp_state_reg;
        lat_cnt_next   = lat_cnt_reg;
        case (drp_state_reg)
            DRP_IDLE: if (den_in) begin
                lat_cnt_next   = LAT_INIT;
                drp_state_next = (DRP_LAT == 1) ? DRP_RESP : DRP_WAIT;
            end
            DRP_WAIT: begin
                lat_cnt_next = lat_cnt_reg - 4'd1;
                if (lat_cnt_reg == 4'd1)
                    drp_state_next = DRP_RESP;
            end
            default: drp_state_next = DRP_IDLE;
        endcase
    end

    always_comb begin
        drdy_out = (drp_state_reg == DRP_RESP);
        do_out   = (drp_state_reg == DRP_RESP && !wr_flag_reg) ? snap_reg : 16'h0;
        err_out  = err_reg;
    end

    // Round-robin: first enabled channel above pick_base, wrapping; base 3 yields the lowest.
    always_comb begin
        pick_base = (seq_state_reg == SEQ_OFF) ? 2'd3 : sel_reg;
        pick_idx  = pick_base;
        for (int i = 4; i >= 1; i--) begin
            if (eff_mask[pick_base + 2'(i)])
                pick_idx = pick_base + 2'(i);
        end
    end

    // Sequencer FSM
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            seq_state_reg <= SEQ_OFF;
            timer_reg     <= '0;
            sel_reg       <= '0;
            chan_reg      <= '0;
        end else begin
            seq_state_reg <= seq_state_next;
            timer_reg     <= timer_next;
            sel_reg       <= sel_next;
            if (conv_done)
                chan_reg <= ch_addr(sel_reg);
        end
    end

    always_comb begin
        seq_state_next = seq_state_reg;
        timer_next     = timer_reg;
        sel_next       = sel_reg;
        case (seq_state_reg)
            SEQ_CONV: begin
                if (timer_reg == '0)
                    seq_state_next = SEQ_EOC;
                else
                    timer_next = timer_reg - 1'b1;
            end
            default: begin
                if (eff_mask != 4'h0) begin
                    sel_next       = pick_idx;
                    timer_next     = CONV_INIT;
                    seq_state_next = SEQ_CONV;
                end else begin
                    seq_state_next = SEQ_OFF;
                end
            end
        endcase
    end

    always_comb begin
        busy_out    = (seq_state_reg == SEQ_CONV);
        eoc_out     = (seq_state_reg == SEQ_EOC);
        channel_out = chan_reg;
    end
endmodule

// File: tb/tb_xadc_drp_responder.sv
// Directed bench for xadc_drp_responder: stimulus pushes expected responses into queues,
// a negedge monitor pops and compares them as drdy_out / eoc_out appear.
module tb_xadc_drp_responder;
    localparam int LAT  = 4;
    localparam int CONV = 26;

    logic        CLK100MHZ = 1'b0;
    logic        CPU_RESETN;
    logic [6:0]  daddr_in;
    logic        den_in, den_drv, dwe_in, loop_mode;
    logic [15:0] di_in;
    logic [15:0] do_out;
    logic        drdy_out, busy_out, eoc_out, err_out;
    logic [4:0]  channel_out;
    logic [11:0] aux2_in, aux3_in, aux10_in, aux11_in;

    typedef struct {
        int          t;
        logic [15:0] d;
    } drp_exp_t;

    drp_exp_t   drq[$];
    logic [4:0] chq[$];
    int errors = 0;
    int checks = 0;
    int cyc;
    int last_eoc = 0;

    xadc_drp_responder #(.DRP_LAT(LAT), .CONV_CYCLES(CONV), .SEQ_RST(4'hF)) dut (
        .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN),
        .daddr_in(daddr_in), .den_in(den_in), .dwe_in(dwe_in), .di_in(di_in),
        .do_out(do_out), .drdy_out(drdy_out), .busy_out(busy_out), .eoc_out(eoc_out),
        .channel_out(channel_out), .err_out(err_out),
        .aux2_in(aux2_in), .aux3_in(aux3_in), .aux10_in(aux10_in), .aux11_in(aux11_in)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;
    assign den_in = loop_mode ? eoc_out : den_drv;

    always @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) cyc <= 0;
        else             cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cyc %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic drp(input logic [6:0] a, input logic we, input logic [15:0] d,
                       input logic [15:0] exp);
        drp_exp_t e;
        e.t = cyc + LAT;
        e.d = we ? 16'h0 : exp;
        drq.push_back(e);
        daddr_in = a; dwe_in = we; di_in = d; den_drv = 1'b1;
        $display("drp %s addr=%h data=%h cyc=%0d", we ? "write" : "read", a, d, cyc);
        step();
        den_drv = 1'b0; dwe_in = 1'b0;
        repeat (LAT) step();
    endtask

    task automatic wait_eoc(input logic [4:0] ch);
        int n;
        n = 0;
        chq.push_back(ch);
        step();
        while (!eoc_out && n < 60) begin
            step();
            n++;
        end
        check("eoc_seen", eoc_out, 1);
    endtask

    initial begin : monitor
        drp_exp_t e;
        forever begin
            @(negedge CLK100MHZ);
            if (!CPU_RESETN) begin
                last_eoc = 0;
            end else begin
                if (drdy_out) begin
                    if (drq.size() == 0) begin
                        check("unexpected_drdy", drdy_out, 0);
                    end else begin
                        e = drq.pop_front();
                        check("drdy_cycle", cyc, e.t);
                        check("do_out", do_out, e.d);
                        $display("drp response cyc=%0d do_out=%h", cyc, do_out);
                    end
                end else begin
                    check("do_idle_zero", do_out, 0);
                end
                if (cyc >= 1) check("busy_vs_eoc", busy_out, !eoc_out);
                if (eoc_out) begin
                    check("eoc_interval", cyc - last_eoc, CONV);
                    last_eoc = cyc;
                    if (loop_mode) begin
                        e.t = cyc + LAT;
                        e.d = 16'hABC0;
                        drq.push_back(e);
                    end
                    if (chq.size() > 0) check("channel_out", channel_out, chq.pop_front());
                    $display("eoc cyc=%0d channel=%h", cyc, channel_out);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        CPU_RESETN = 1'b0; den_drv = 1'b0; dwe_in = 1'b0; daddr_in = 7'h12; di_in = '0;
        loop_mode = 1'b1;
        aux2_in = 12'hABC; aux3_in = 12'h123; aux10_in = 12'h456; aux11_in = 12'h789;
        repeat (3) @(posedge CLK100MHZ);
        #1;
        check("reset_outputs", {do_out, drdy_out, busy_out, eoc_out, channel_out, err_out}, 0);
        CPU_RESETN = 1'b1;

        // eoc looped into den_in reading 0x12
        wait_eoc(5'h12);
        check("first_eoc_cycle", cyc, CONV);
        wait_eoc(5'h13);
        wait_eoc(5'h1A);
        wait_eoc(5'h1B);
        wait_eoc(5'h12);
        step();
        loop_mode = 1'b0;
        repeat (LAT + 1) step();

        // mask change to aux2/aux10 only; ongoing aux3 conversion completes first
        drp(7'h41, 1'b1, 16'h0005, 16'h0);
        drp(7'h41, 1'b0, 16'h0, 16'h0005);
        wait_eoc(5'h13);
        wait_eoc(5'h1A);
        wait_eoc(5'h12);
        wait_eoc(5'h1A);

        drp(7'h13, 1'b1, 16'hFFFF, 16'h0);
        drp(7'h13, 1'b0, 16'h0, 16'h1230);
        drp(7'h7F, 1'b0, 16'h0, 16'h0);
        drp(7'h40, 1'b1, 16'hBEEF, 16'h0);
        drp(7'h40, 1'b0, 16'h0, 16'hBEEF);
        drp(7'h42, 1'b1, 16'h1234, 16'h0);
        drp(7'h42, 1'b0, 16'h0, 16'h1234);
        check("err_clear", err_out, 0);

        // second den two cycles into an accepted read: ignored, flagged
        begin
            drp_exp_t e;
            e.t = cyc + LAT;
            e.d = 16'hBEEF;
            drq.push_back(e);
        end
        daddr_in = 7'h40; dwe_in = 1'b0; den_drv = 1'b1;
        step(); den_drv = 1'b0;
        step(); den_drv = 1'b1;
        step(); den_drv = 1'b0;
        repeat (4) step();
        check("err_set", err_out, 1);
        repeat (5) step();
        check("err_sticky", err_out, 1);

        // reset two cycles after den: transaction dropped
        daddr_in = 7'h40; den_drv = 1'b1;
        $display("drp read addr=40 (dropped by reset) cyc=%0d", cyc);
        step(); den_drv = 1'b0;
        step();
        CPU_RESETN = 1'b0;
        #1;
        check("reset_mid_outputs", {do_out, drdy_out, busy_out, eoc_out, channel_out, err_out}, 0);
        step();
        check("reset_hold_outputs", {do_out, drdy_out, busy_out, eoc_out, channel_out, err_out}, 0);
        step();
        CPU_RESETN = 1'b1;

        drp(7'h12, 1'b0, 16'h0, 16'h0000);
        drp(7'h41, 1'b0, 16'h0, 16'h000F);
        check("err_after_reset", err_out, 0);
        aux2_in = 12'h5A5;
        wait_eoc(5'h12);
        check("eoc_after_reset_cycle", cyc, CONV);
        drp(7'h12, 1'b0, 16'h0, 16'h5A50);

        repeat (10) step();
        check("drdy_pending", drq.size(), 0);
        check("eoc_pending", chq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
